// File: rtl/rs_syndrome_sched.sv
// Reed-Solomon syndrome scheduler: Horner accumulation of S1 = r(alpha) and
// S2 = r(alpha^2) over GF(2^5), with codeword framing and a result hold stage.
module rs_syndrome_sched #(
  parameter int NSYM = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sym_data,
  input  logic       sym_valid,
  input  logic       sym_first,
  input  logic       sym_last,
  output logic       sym_ready,
  output logic [4:0] syn1,
  output logic [4:0] syn2,
  output logic       syn_err,
  output logic       len_err,
  output logic       syn_valid,
  input  logic       syn_ready
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [4:0] NSYM_L = 5'(NSYM);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] s1_q, s1_d;
  logic [4:0] s2_q, s2_d;
  logic       syn_err_q, syn_err_d;
  logic       len_err_q, len_err_d;
  logic       act_q, act_d;

  logic       accept;
  logic       close;
  logic       len_bad;
  logic [4:0] cnt_nxt;

  // Multiply by alpha modulo x^5 + x^2 + 1.
  function automatic logic [4:0] mul_a(input logic [4:0] x);
    mul_a = {x[3:0], 1'b0} ^ (x[4] ? 5'h05 : 5'h00);
  endfunction

  function automatic logic [4:0] mul_a2(input logic [4:0] x);
    mul_a2 = mul_a(mul_a(x));
  endfunction

  function automatic logic [4:0] cnt_inc(input logic [4:0] c);
    cnt_inc = (c == 5'd31) ? 5'd31 : c + 5'd1;
  endfunction

  // act_q holds sym_ready low until the first edge after reset release.
  assign sym_ready = act_q && (state_q != HOLD);
  assign accept    = sym_valid && sym_ready;
  assign cnt_nxt   = cnt_inc(cnt_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    syn_err_d = syn_err_q;
    len_err_d = len_err_q;
    act_d     = 1'b1;
    close     = 1'b0;
    len_bad   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && sym_first) begin
          s1_d  = sym_data;
          s2_d  = sym_data;
          cnt_d = 5'd1;
          if (sym_last) begin
            close   = 1'b1;
            len_bad = (NSYM_L != 5'd1);
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          if (sym_first) begin
            // A new first symbol abandons the partial codeword silently.
            s1_d  = sym_data;
            s2_d  = sym_data;
            cnt_d = 5'd1;
            if (sym_last) begin
              close   = 1'b1;
              len_bad = (NSYM_L != 5'd1);
            end
          end else begin
            s1_d  = mul_a(s1_q) ^ sym_data;
            s2_d  = mul_a2(s2_q) ^ sym_data;
            cnt_d = cnt_nxt;
            if (sym_last) begin
              close   = 1'b1;
              len_bad = (cnt_nxt != NSYM_L);
            end else if (cnt_nxt == NSYM_L) begin
              close   = 1'b1;
              len_bad = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (syn_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (close) begin
      state_d   = HOLD;
      syn_err_d = (s1_d != 5'h00) || (s2_d != 5'h00);
      len_err_d = len_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      s1_q      <= 5'h00;
      s2_q      <= 5'h00;
      syn_err_q <= 1'b0;
      len_err_q <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      syn_err_q <= syn_err_d;
      len_err_q <= len_err_d;
      act_q     <= act_d;
    end
  end

  assign syn1      = s1_q;
  assign syn2      = s2_q;
  assign syn_err   = syn_err_q;
  assign len_err   = len_err_q;
  assign syn_valid = (state_q == HOLD);

endmodule

// File: tb/tb_rs_syndrome_sched.sv
// Self-checking bench for rs_syndrome_sched: directed framing cases plus
// randomized codewords scored against a polynomial-evaluation model.
module tb_rs_syndrome_sched;

  localparam int NSYM = 31;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sym_data;
  logic       sym_valid;
  logic       sym_first;
  logic       sym_last;
  logic       sym_ready;
  logic [4:0] syn1;
  logic [4:0] syn2;
  logic       syn_err;
  logic       len_err;
  logic       syn_valid;
  logic       syn_ready;

  int checks = 0;
  int errors = 0;
  logic [4:0] cw[$];

  rs_syndrome_sched #(.NSYM(NSYM)) dut (
    .clk(clk), .rst(rst),
    .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_first(sym_first), .sym_last(sym_last), .sym_ready(sym_ready),
    .syn1(syn1), .syn2(syn2), .syn_err(syn_err), .len_err(len_err),
    .syn_valid(syn_valid), .syn_ready(syn_ready)
  );

  always #5 clk = ~clk;

  // Reference field arithmetic: general GF(2^5) product and powers of alpha.
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] p;
    logic [4:0] x;
    p = 5'h00;
    x = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) p = p ^ x;
      x = x[4] ? ({x[3:0], 1'b0} ^ 5'h05) : {x[3:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [4:0] gf_pow(input int e);
    logic [4:0] r;
    r = 5'h01;
    for (int i = 0; i < e; i++) r = gf_mul(r, 5'h02);
    return r;
  endfunction

  // r(alpha^k) with cw[0] as the highest-degree coefficient.
  function automatic logic [4:0] eval_syn(input int k);
    logic [4:0] s;
    int n;
    s = 5'h00;
    n = cw.size();
    for (int i = 0; i < n; i++) s = s ^ gf_mul(cw[i], gf_pow(k * (n - 1 - i)));
    return s;
  endfunction

  task automatic drive(input logic [4:0] d, input logic f, input logic l);
    int g;
    @(negedge clk);
    sym_data  = d;
    sym_first = f;
    sym_last  = l;
    sym_valid = 1'b1;
    g = 0;
    while (!sym_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL drive_ready_timeout sym_ready=%b required 1", sym_ready);
    end
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_first = 1'b0;
    sym_last  = 1'b0;
  endtask

  task automatic send_cw(input bit with_last, output int early);
    early = 0;
    foreach (cw[i]) begin
      drive(cw[i], i == 0, with_last && (i == cw.size() - 1));
      if (i != cw.size() - 1 && syn_valid) early++;
    end
  endtask

  task automatic consume();
    syn_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sym_ready !== 1'b0 || syn_valid !== 1'b0 || syn1 !== 5'h00 || syn2 !== 5'h00 ||
        syn_err !== 1'b0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdy=%b sv=%b s1=%h s2=%h se=%b le=%b required 0 0 00 00 0 0",
               sym_ready, syn_valid, syn1, syn2, syn_err, len_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (sym_ready !== 1'b1 || syn_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b sv=%b required 1 0", sym_ready, syn_valid);
    end
  endtask

  task automatic test_zero_word();
    int early;
    cw.delete();
    for (int i = 0; i < NSYM; i++) cw.push_back(5'h00);
    send_cw(1'b1, early);
    checks++;
    if (early !== 0 || syn_valid !== 1'b1 || syn1 !== 5'h00 || syn2 !== 5'h00 ||
        syn_err !== 1'b0 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_word early=%0d sv=%b s1=%h s2=%h se=%b le=%b required 0 1 00 00 0 0",
               early, syn_valid, syn1, syn2, syn_err, len_err);
    end
    consume();
    checks++;
    if (syn_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_word_release sv=%b required 0", syn_valid);
    end
  endtask

  task automatic test_first_one();
    int early;
    cw.delete();
    cw.push_back(5'h01);
    for (int i = 1; i < NSYM; i++) cw.push_back(5'h00);
    send_cw(1'b1, early);
    checks++;
    if (early !== 0 || syn_valid !== 1'b1 || syn1 !== 5'h12 || syn2 !== 5'h09 ||
        syn_err !== 1'b1 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL first_one early=%0d sv=%b s1=%h s2=%h se=%b le=%b required 0 1 12 09 1 0",
               early, syn_valid, syn1, syn2, syn_err, len_err);
    end
    consume();
  endtask

  task automatic test_hold_backpressure();
    int early;
    cw.delete();
    for (int i = 0; i < NSYM - 1; i++) cw.push_back(5'h00);
    cw.push_back(5'h01);
    syn_ready = 1'b0;
    send_cw(1'b1, early);
    checks++;
    if (early !== 0 || syn_valid !== 1'b1 || syn1 !== 5'h01 || syn2 !== 5'h01 ||
        syn_err !== 1'b1 || len_err !== 1'b0) begin
      errors++;
      $display("FAIL last_one early=%0d sv=%b s1=%h s2=%h se=%b le=%b required 0 1 01 01 1 0",
               early, syn_valid, syn1, syn2, syn_err, len_err);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (syn_valid !== 1'b1 || sym_ready !== 1'b0 || syn1 !== 5'h01 || syn2 !== 5'h01 ||
          syn_err !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d sv=%b rdy=%b s1=%h s2=%h se=%b required 1 0 01 01 1",
                 c, syn_valid, sym_ready, syn1, syn2, syn_err);
      end
    end
    consume();
    checks++;
    if (syn_valid !== 1'b0 || sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release sv=%b rdy=%b required 0 1", syn_valid, sym_ready);
    end
  endtask

  task automatic test_length_errors();
    int early;
    cw.delete();
    for (int i = 0; i < 11; i++) cw.push_back(5'($urandom_range(0, 31)));
    send_cw(1'b1, early);
    checks++;
    if (early !== 0 || syn_valid !== 1'b1 || len_err !== 1'b1 || syn1 !== eval_syn(1) ||
        syn2 !== eval_syn(2)) begin
      errors++;
      $display("FAIL short_word early=%0d sv=%b le=%b s1=%h s2=%h required 0 1 1 %h %h",
               early, syn_valid, len_err, syn1, syn2, eval_syn(1), eval_syn(2));
    end
    consume();
    cw.delete();
    for (int i = 0; i < NSYM; i++) cw.push_back(5'($urandom_range(0, 31)));
    send_cw(1'b0, early);
    checks++;
    if (early !== 0 || syn_valid !== 1'b1 || len_err !== 1'b1 || syn1 !== eval_syn(1) ||
        syn2 !== eval_syn(2)) begin
      errors++;
      $display("FAIL no_last_word early=%0d sv=%b le=%b s1=%h s2=%h required 0 1 1 %h %h",
               early, syn_valid, len_err, syn1, syn2, eval_syn(1), eval_syn(2));
    end
    consume();
  endtask

  task automatic test_restart();
    int early;
    int extra;
    cw.delete();
    for (int i = 0; i < 15; i++) cw.push_back(5'($urandom_range(1, 31)));
    send_cw(1'b0, early);
    cw.delete();
    for (int i = 0; i < NSYM; i++) cw.push_back(5'h00);
    send_cw(1'b1, extra);
    checks++;
    if (early !== 0 || extra !== 0 || syn_valid !== 1'b1 || syn1 !== 5'h00 ||
        syn2 !== 5'h00 || len_err !== 1'b0 || syn_err !== 1'b0) begin
      errors++;
      $display("FAIL restart early=%0d/%0d sv=%b s1=%h s2=%h le=%b se=%b required 0/0 1 00 00 0 0",
               early, extra, syn_valid, syn1, syn2, len_err, syn_err);
    end
    consume();
    extra = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (syn_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL restart_single_result extra_valid=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int early;
    int bad;
    cw.delete();
    for (int i = 0; i < 20; i++) cw.push_back(5'h01);
    send_cw(1'b0, early);
    rst = 1'b1;
    #1;
    checks++;
    if (syn1 !== 5'h00 || syn2 !== 5'h00 || sym_ready !== 1'b0 || syn_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset s1=%h s2=%h rdy=%b sv=%b required 00 00 0 0",
               syn1, syn2, sym_ready, syn_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 20; i < NSYM; i++) begin
      drive(5'h01, 1'b0, i == NSYM - 1);
      if (syn_valid) bad++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (syn_valid) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_discard valid_cycles=%0d required 0", bad);
    end
    test_zero_word();
  endtask

  task automatic test_random();
    int early;
    int junk;
    int len;
    int hold;
    bit ovf;
    logic [4:0] e1, e2;
    logic exp_se, exp_le;
    for (int n = 0; n < 20; n++) begin
      junk = $urandom_range(0, 3);
      early = 0;
      for (int j = 0; j < junk; j++) begin
        drive(5'($urandom_range(0, 31)), 1'b0, 1'($urandom_range(0, 1)));
        if (syn_valid) early++;
      end
      ovf = ($urandom_range(0, 3) == 0);
      len = ovf ? NSYM : $urandom_range(2, NSYM);
      cw.delete();
      for (int i = 0; i < len; i++) cw.push_back(5'($urandom_range(0, 31)));
      hold = $urandom_range(0, 3);
      syn_ready = (hold == 0);
      begin
        int e2cnt;
        send_cw(!ovf, e2cnt);
        early += e2cnt;
      end
      e1 = eval_syn(1);
      e2 = eval_syn(2);
      exp_se = (e1 != 5'h00) || (e2 != 5'h00);
      exp_le = ovf ? 1'b1 : (len != NSYM);
      checks++;
      if (early !== 0 || syn_valid !== 1'b1 || syn1 !== e1 || syn2 !== e2 ||
          syn_err !== exp_se || len_err !== exp_le) begin
        errors++;
        $display("FAIL random n=%0d len=%0d early=%0d sv=%b s1=%h s2=%h se=%b le=%b required 0 1 %h %h %b %b",
                 n, len, early, syn_valid, syn1, syn2, syn_err, len_err, e1, e2, exp_se, exp_le);
      end
      repeat (hold) @(posedge clk);
      #1;
      checks++;
      if (syn_valid !== 1'b1 || syn1 !== e1 || syn2 !== e2) begin
        errors++;
        $display("FAIL random_hold n=%0d sv=%b s1=%h s2=%h required 1 %h %h",
                 n, syn_valid, syn1, syn2, e1, e2);
      end
      consume();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int early;
    logic [4:0] e1, e2;
    syn_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      cw.delete();
      for (int i = 0; i < NSYM; i++) cw.push_back(5'($urandom_range(0, 31)));
      send_cw(1'b1, early);
      e1 = eval_syn(1);
      e2 = eval_syn(2);
      checks++;
      if (early !== 0 || syn_valid !== 1'b1 || syn1 !== e1 || syn2 !== e2 || len_err !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back w=%0d early=%0d sv=%b s1=%h s2=%h le=%b required 0 1 %h %h 0",
                 w, early, syn_valid, syn1, syn2, len_err, e1, e2);
      end
    end
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    sym_data  = 5'h00;
    sym_valid = 1'b0;
    sym_first = 1'b0;
    sym_last  = 1'b0;
    syn_ready = 1'b1;
    test_reset();
    test_zero_word();
    test_first_one();
    test_hold_backpressure();
    test_length_errors();
    test_restart();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_sched.md
RS_SYNDROME_SCHED -- requirements
Module: rs_syndrome_sched

Interface
REQ-001 Parameter NSYM, default 31, symbols per codeword (legal 2..31).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sym_data  input  5  received GF(2^5) symbol, highest-degree coefficient first.
REQ-005 sym_valid  input  1  sym_data/sym_first/sym_last valid.
REQ-006 sym_first  input  1  beat carries the first symbol of a codeword.
REQ-007 sym_last  input  1  beat carries the last symbol of a codeword.
REQ-008 sym_ready  output  1  block accepts a beat this cycle.
REQ-009 syn1  output  5  syndrome S1 = r(alpha).
REQ-010 syn2  output  5  syndrome S2 = r(alpha^2).
REQ-011 syn_err  output  1  at least one syndrome is nonzero.
REQ-012 len_err  output  1  codeword length differed from NSYM.
REQ-013 syn_valid  output  1  syn1/syn2/syn_err/len_err valid.
REQ-014 syn_ready  input  1  consumer accepts the result.

Function
REQ-015 Field GF(2^5), primitive polynomial x^5+x^2+1; multiply by alpha = shift left by one, XOR 5'h05 when the shifted-out bit is 1; multiply by alpha^2 = two such steps.
REQ-016 Beat accepted when sym_valid=1 and sym_ready=1; no other cycle changes accumulators.
REQ-017 Accumulation (Horner): S1 <= S1*alpha XOR sym_data, S2 <= S2*alpha^2 XOR sym_data; the first-symbol beat loads S1=S2=sym_data.
REQ-018 States IDLE, ACC, HOLD; sym_ready=1 in IDLE and ACC, 0 in HOLD.
REQ-019 IDLE: beats with sym_first=0 are accepted and discarded; sym_first=1 loads accumulators, count=1, goes to ACC (or HOLD if sym_last=1 on the same beat).
REQ-020 ACC: each accepted beat accumulates and increments count; sym_last=1 goes to HOLD.
REQ-021 ACC: sym_first=1 aborts the current codeword without output, reloads accumulators from this beat, count=1.
REQ-022 ACC: count reaching NSYM without sym_last sets len_err=1 and goes to HOLD on that beat.
REQ-023 len_err=1 when the closing beat's count differs from NSYM; 0 otherwise.
REQ-024 HOLD: syn_valid=1; outputs stable until syn_valid and syn_ready both high, then IDLE on the next edge.
REQ-025 Latency: syn_valid rises the cycle after the closing beat is accepted.
REQ-026 syn_err = (syn1 != 0) or (syn2 != 0), registered with syndromes.
REQ-027 Count is 5-bit, saturating; never wraps.

Reset
REQ-028 rst=1 forces state IDLE, count=0, S1=S2=0, syn_valid=0, syn_err=0, len_err=0, sym_ready=0 while asserted, immediately and independent of clk.
REQ-029 Reset mid-codeword or during HOLD discards the codeword; no syn_valid after release until a new full codeword.
REQ-030 sym_ready=1 from the first edge after rst deasserts.

Verification
REQ-031 31 beats of 5'h00 (first on beat 0, last on beat 30) -> syn1=0, syn2=0, syn_err=0, len_err=0, syn_valid one cycle after beat 30.
REQ-032 Beat 0 = 5'h01, beats 1..30 = 0 -> syn1=5'h12, syn2=5'h09, syn_err=1.
REQ-033 Beats 0..29 = 0, beat 30 = 5'h01 -> syn1=5'h01, syn2=5'h01, syn_err=1; hold syn_ready=0 five cycles -> outputs stable, sym_ready=0.
REQ-034 sym_last on beat 10 -> len_err=1; 31 beats with no sym_last -> len_err=1 at beat 30.
REQ-035 sym_first reissued at beat 15 then 31 zero beats -> single result, syndromes 0, len_err=0.
REQ-036 rst pulse at beat 20 -> syn_valid stays 0; next clean codeword yields REQ-031 results.
